// File: rtl/hyperbus_burst_splitter.sv
// Splits AXI INCR bursts into sub-bursts of at most MAX_BEATS beats; HYPERBUS_SPLITTER_ROW_EN also stops them at ROW_BYTES rows.
// Latency 1 cycle from input handshake to first sub-burst; outputs held while out_ready_i is low; no new request accepted until the current one is fully issued.
module hyperbus_burst_splitter #(
    parameter int AXI_AW    = 32,
    parameter int AXI_IW    = 10,
    parameter int MAX_BEATS = 16,
    parameter int ROW_BYTES = 1024
) (
    input  logic              clk_sys_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [AXI_AW-1:0] in_addr_i,
    input  logic [7:0]        in_len_i,
    input  logic [2:0]        in_size_i,
    input  logic [AXI_IW-1:0] in_id_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [AXI_AW-1:0] out_addr_o,
    output logic [7:0]        out_len_o,
    output logic [2:0]        out_size_o,
    output logic [AXI_IW-1:0] out_id_o,
    output logic              out_last_o,
    output logic              busy_o
);

    localparam int RB = $clog2(ROW_BYTES);
    // Wide enough for remaining beats (<=256), MAX_BEATS and a full row's byte count.
    localparam int CW = RB + 3;

    typedef enum logic {IDLE, SPLIT} state_e;

    state_e            state_q, state_d;
    logic [AXI_AW-1:0] addr_q, addr_d;
    logic [8:0]        rem_q, rem_d;
    logic [2:0]        size_q, size_d;
    logic [AXI_IW-1:0] id_q, id_d;

    logic [AXI_AW-1:0] align_mask;
    logic [AXI_AW-1:0] aligned_addr;
    logic [AXI_AW-1:0] step;
    logic [CW-1:0]     chunk;
`ifdef HYPERBUS_SPLITTER_ROW_EN
    logic [CW-1:0]     row_left;
    logic [CW-1:0]     row_beats;
`endif

    always_comb begin
        align_mask   = {AXI_AW{1'b1}} << size_q;
        aligned_addr = addr_q & align_mask;
        chunk        = {{(CW-9){1'b0}}, rem_q};
        if (chunk > CW'(MAX_BEATS)) begin
            chunk = CW'(MAX_BEATS);
        end
`ifdef HYPERBUS_SPLITTER_ROW_EN
        row_left  = CW'(ROW_BYTES) - {{(CW-RB){1'b0}}, aligned_addr[RB-1:0]};
        row_beats = row_left >> size_q;
        if (row_beats < chunk) begin
            chunk = row_beats;
        end
`endif
        step = {{(AXI_AW-CW){1'b0}}, chunk} << size_q;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        size_d  = size_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    addr_d  = in_addr_i;
                    rem_d   = {1'b0, in_len_i} + 9'd1;
                    size_d  = in_size_i;
                    id_d    = in_id_i;
                    state_d = SPLIT;
                end
            end
            SPLIT: begin
                if (out_ready_i) begin
                    // Later sub-bursts restart from the size-aligned address.
                    addr_d = aligned_addr + step;
                    rem_d  = rem_q - chunk[8:0];
                    if (rem_q == chunk[8:0]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            size_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            size_q  <= size_d;
            id_q    <= id_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == SPLIT);
    assign busy_o      = (state_q == SPLIT);
    assign out_addr_o  = addr_q;
    assign out_len_o   = (state_q == SPLIT) ? (chunk[7:0] - 8'd1) : 8'd0;
    assign out_size_o  = size_q;
    assign out_id_o    = id_q;
    assign out_last_o  = (state_q == SPLIT) && (chunk == {{(CW-9){1'b0}}, rem_q});

endmodule

// File: tb/tb_hyperbus_burst_splitter.sv
// Scoreboard bench for hyperbus_burst_splitter; expectations follow HYPERBUS_SPLITTER_ROW_EN.
module tb_hyperbus_burst_splitter;

    logic        clk_sys_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_addr_i;
    logic [7:0]  in_len_i;
    logic [2:0]  in_size_i;
    logic [9:0]  in_id_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_addr_o;
    logic [7:0]  out_len_o;
    logic [2:0]  out_size_o;
    logic [9:0]  out_id_o;
    logic        out_last_o;
    logic        busy_o;

    always #5 clk_sys_i = ~clk_sys_i;

    hyperbus_burst_splitter #(
        .AXI_AW(32), .AXI_IW(10), .MAX_BEATS(16), .ROW_BYTES(1024)
    ) dut (
        .clk_sys_i(clk_sys_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_addr_i(in_addr_i), .in_len_i(in_len_i), .in_size_i(in_size_i), .in_id_i(in_id_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_addr_o(out_addr_o), .out_len_o(out_len_o), .out_size_o(out_size_o), .out_id_o(out_id_o),
        .out_last_o(out_last_o), .busy_o(busy_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [9:0]  id;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                        input logic [9:0] id, input logic last);
        beat_t b;
        b.addr = a; b.len = l; b.size = s; b.id = id; b.last = last;
        exp_q.push_back(b);
    endtask

    // Monitor: samples 1 time unit after the falling edge.
    beat_t cur, prev, exp_b;
    logic  prev_stall = 1'b0;
    logic  prev_rst   = 1'b1;
    initial begin
        forever begin
            @(negedge clk_sys_i);
            #1;
            cur = {out_addr_o, out_len_o, out_size_o, out_id_o, out_last_o};
            if (prev_stall && !prev_rst && !rst_i) begin
                chk("hold_valid", 64'(out_valid_o), 64'd1);
                chk("hold_outputs", 64'(cur), 64'(prev));
            end
            if (out_valid_o) begin
                chk("in_ready_in_split", 64'(in_ready_o), 64'd0);
            end
            if (out_valid_o && out_ready_i && !rst_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_subburst", 64'(cur), 64'd0);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("subburst", 64'(cur), 64'(exp_b));
                end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_rst   = rst_i;
            prev       = cur;
        end
    end

    task automatic send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                        input logic [9:0] id);
        int n = 0;
        @(negedge clk_sys_i);
        while (!in_ready_o && n < 200) begin
            @(negedge clk_sys_i);
            n++;
        end
        if (!in_ready_o) chk("send_timeout", 64'd0, 64'd1);
        in_addr_i  = a;
        in_len_i   = l;
        in_size_i  = s;
        in_id_i    = id;
        in_valid_i = 1'b1;
        @(negedge clk_sys_i);
        in_valid_i = 1'b0;
        chk("first_latency", 64'(out_valid_o), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy_o || exp_q.size() != 0) && n < 500) begin
            @(negedge clk_sys_i);
            n++;
        end
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        chk("drain_idle", 64'(busy_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
        in_addr_i = '0; in_len_i = '0; in_size_i = '0; in_id_i = '0;
        repeat (3) @(negedge clk_sys_i);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_last", 64'(out_last_o), 64'd0);
        chk("rst_addr", 64'(out_addr_o), 64'd0);
        chk("rst_len", 64'(out_len_o), 64'd0);
        chk("rst_id", 64'(out_id_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        rst_i = 1'b0;

        // Single sub-burst.
        push(32'h100, 8'd3, 3'd3, 10'd1, 1'b1);
        send(32'h100, 8'd3, 3'd3, 10'd1);
        drain();

        // MAX_BEATS split.
        push(32'h000, 8'd15, 3'd2, 10'd2, 1'b0);
        push(32'h040, 8'd15, 3'd2, 10'd2, 1'b0);
        push(32'h080, 8'd7,  3'd2, 10'd2, 1'b1);
        send(32'h0, 8'd39, 3'd2, 10'd2);
        drain();

        // Row crossing.
`ifdef HYPERBUS_SPLITTER_ROW_EN
        push(32'h3F0, 8'd1, 3'd3, 10'd3, 1'b0);
        push(32'h400, 8'd5, 3'd3, 10'd3, 1'b1);
`else
        push(32'h3F0, 8'd7, 3'd3, 10'd3, 1'b1);
`endif
        send(32'h3F0, 8'd7, 3'd3, 10'd3);
        drain();

        // Address wrap at the top of the space.
`ifdef HYPERBUS_SPLITTER_ROW_EN
        push(32'hFFFF_FFF8, 8'd0, 3'd3, 10'd4, 1'b0);
        push(32'h0000_0000, 8'd0, 3'd3, 10'd4, 1'b1);
`else
        push(32'hFFFF_FFF8, 8'd1, 3'd3, 10'd4, 1'b1);
`endif
        send(32'hFFFF_FFF8, 8'd1, 3'd3, 10'd4);
        drain();

        // Unaligned start: later sub-bursts become size-aligned.
        push(32'h102, 8'd15, 3'd2, 10'd5, 1'b0);
        push(32'h140, 8'd4,  3'd2, 10'd5, 1'b1);
        send(32'h102, 8'd20, 3'd2, 10'd5);
        drain();

        // Single beat and the longest AXI burst.
        push(32'h7, 8'd0, 3'd0, 10'd8, 1'b1);
        send(32'h7, 8'd0, 3'd0, 10'd8);
        drain();
        for (int i = 0; i < 16; i++) begin
            push(32'(i * 16), 8'd15, 3'd0, 10'h3FF, i == 15);
        end
        send(32'h0, 8'd255, 3'd0, 10'h3FF);
        drain();

        // Backpressure for 5 cycles.
        out_ready_i = 1'b0;
        push(32'h010, 8'd15, 3'd0, 10'd6, 1'b0);
        push(32'h020, 8'd3,  3'd0, 10'd6, 1'b1);
        send(32'h10, 8'd19, 3'd0, 10'd6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys_i);
            chk("stall_in_ready", 64'(in_ready_o), 64'd0);
            chk("stall_addr", 64'(out_addr_o), 64'h10);
        end
        out_ready_i = 1'b1;
        drain();

        // Reset during the second of three sub-bursts.
        push(32'h000, 8'd15, 3'd2, 10'd7, 1'b0);
        send(32'h0, 8'd39, 3'd2, 10'd7);
        @(negedge clk_sys_i);
        chk("second_addr", 64'(out_addr_o), 64'h40);
        rst_i = 1'b1;
        out_ready_i = 1'b0;
        @(negedge clk_sys_i);
        chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys_i);
            chk("post_rst_quiet", 64'(out_valid_o), 64'd0);
        end
        chk("post_rst_queue", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hyperbus_burst_splitter.md
HYPERBUS_BURST_SPLITTER -- requirements
Module: hyperbus_burst_splitter

Interface
REQ-001 SHALL have parameter AXI_AW, default 32, address width in bits.
REQ-002 SHALL have parameter AXI_IW, default 10, transaction ID width in bits.
REQ-003 SHALL have parameter MAX_BEATS, default 16, maximum beats per sub-burst; legal range 1..256.
REQ-004 SHALL have parameter ROW_BYTES, default 1024, row boundary in bytes; power of two, at least 128.
REQ-005 SHALL have port clk_sys_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1): upstream AXI AR/AW-style handshake.
REQ-008 SHALL have ports in_addr_i (input, AXI_AW), in_len_i (input, 8), in_size_i (input, 3) and in_id_i (input, AXI_IW): INCR burst request with AXI len/size encoding.
REQ-009 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1): downstream sub-burst handshake toward the HyperBus controller.
REQ-010 SHALL have ports out_addr_o (output, AXI_AW), out_len_o (output, 8), out_size_o (output, 3) and out_id_o (output, AXI_IW): sub-burst request.
REQ-011 SHALL have port out_last_o, output, 1 bit: set on the final sub-burst of the original request.
REQ-012 SHALL have port busy_o, output, 1 bit: high in state SPLIT.

Function
REQ-013 SHALL implement FSM states IDLE and SPLIT.
REQ-014 In IDLE, in_ready_o SHALL be 1 and out_valid_o SHALL be 0; in SPLIT, in_ready_o SHALL be 0 and out_valid_o SHALL be 1.
REQ-015 On in_valid_i && in_ready_o, the block SHALL capture addr, remaining beats = in_len_i+1 (9 bits), size and id, then enter SPLIT on the next edge; latency from input handshake to out_valid_o is 1 cycle.
REQ-016 chunk SHALL = min(remaining, MAX_BEATS, row_beats), where row_beats = (ROW_BYTES - (aligned_addr mod ROW_BYTES)) >> size and aligned_addr is the current address with bits below size cleared; chunk is always >= 1.
REQ-017 Outputs SHALL be: out_len_o = chunk-1, out_addr_o = current address, out_size_o/out_id_o = captured values, out_last_o = (chunk == remaining).
REQ-018 No combinational path SHALL exist from in_* or out_ready_i to any output.
REQ-019 While out_valid_o && !out_ready_i, all out_* SHALL hold stable.
REQ-020 On out handshake, next address SHALL = aligned_addr + (chunk << size), modulo 2^AXI_AW; remaining SHALL decrease by chunk; the FSM SHALL go to IDLE if remaining reaches 0, else stay in SPLIT.
REQ-021 The first sub-burst SHALL carry the unaligned input address unchanged; every later sub-burst SHALL be size-aligned.
REQ-022 The input SHALL be accepted no earlier than the cycle after the last sub-burst handshake, i.e. no back-to-back overlap.

Reset
REQ-023 While rst_i is high at a clock edge, the state SHALL become IDLE and out_valid_o, out_last_o and busy_o SHALL become 0; in_ready_o SHALL be 1 from the following cycle.
REQ-024 All address, len, id and remaining registers SHALL reset to 0.
REQ-025 Reset mid-SPLIT SHALL discard the pending request with no further sub-bursts.

Configuration
REQ-026 Macro HYPERBUS_SPLITTER_ROW_EN: when defined, the row_beats term of REQ-016 applies; when undefined, chunk = min(remaining, MAX_BEATS), ROW_BYTES is ignored, and sub-bursts may cross rows.

Verification
REQ-027 addr 0x100, len 3, size 3 -> one sub-burst: addr 0x100, len 3, last 1.
REQ-028 addr 0x0, len 39, size 2, MAX_BEATS 16 -> sub-bursts (0x000, len 15), (0x040, len 15), (0x080, len 7); last set only on the third.
REQ-029 ROW_EN defined, addr 0x3F0, len 7, size 3 -> (0x3F0, len 1), (0x400, len 5); ROW_EN undefined -> single (0x3F0, len 7).
REQ-030 out_ready_i held low 5 cycles during SPLIT -> out_* stable and in_ready_o 0 throughout.
REQ-031 rst_i pulsed during the second of three sub-bursts -> out_valid_o 0 next cycle, in_ready_o 1, no further sub-bursts.
REQ-032 ROW_EN defined, addr 0xFFFFFFF8, len 1, size 3 -> (0xFFFFFFF8, len 0), then (0x00000000, len 0, last 1).
